// File: rtl/key_evt_if.sv
// Key event FIFO bus: scanner inputs, pop/flush strobes
// and the queue status seen by the CPLD bus logic.
interface key_evt_if #(
  parameter int ADDR_W = 2
);
  logic [2:0]      key_i3;
  logic            key_vld_i;
  logic            rd_i;
  logic            clr_i;
  logic [3:0]      dout_o4;
  logic [ADDR_W:0] cnt_o;
  logic            empty_o;
  logic            full_o;
  logic            irq_o;
  logic            ovf_o;
  logic            beep_o;

  modport master (
    output key_i3, key_vld_i, rd_i, clr_i,
    input  dout_o4, cnt_o, empty_o, full_o,
    input  irq_o, ovf_o, beep_o
  );

  modport slave (
    input  key_i3, key_vld_i, rd_i, clr_i,
    output dout_o4, cnt_o, empty_o, full_o,
    output irq_o, ovf_o, beep_o
  );
endinterface

// File: rtl/key_evt_fifo.sv
// Keypad event queue: sync + debounce the scanner state,
// queue press/release events and drive a key-click beep.
module key_evt_fifo #(
  parameter int ADDR_W   = 2,
  parameter int DEB_CYC  = 1000000,
  parameter int BEEP_CYC = 2500000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  key_evt_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int DW    = $clog2(DEB_CYC);
  localparam int BW    = $clog2(BEEP_CYC + 1);
  localparam int PW    = ADDR_W + 1;

  logic [3:0]    sync1_r, sync2_r;
  logic [3:0]    cand_r, stable_r;
  logic [3:0]    samp;
  logic [DW-1:0] deb_cnt_r;
  logic          deb_done, fire;
  logic          press, new_ok, old_ok;
  logic          ev_push, beep_hit;
  logic [3:0]    ev_data;

  // Code bits are meaningless while no key is held
  assign samp     = sync2_r[3] ? sync2_r : 4'h0;
  assign deb_done = deb_cnt_r == DW'(DEB_CYC - 1);
  assign fire     = deb_done && (cand_r != stable_r);
  assign press    = cand_r[3];
  assign new_ok   = cand_r[2:0] <= 3'd5;
  assign old_ok   = stable_r[2:0] <= 3'd5;
  assign ev_push  = fire && (press ? new_ok
                                   : (stable_r[3] && old_ok));
  assign ev_data  = press ? {1'b0, cand_r[2:0]}
                          : {1'b1, stable_r[2:0]};
  assign beep_hit = fire && press && new_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_r   <= 4'h0;
      sync2_r   <= 4'h0;
      cand_r    <= 4'h0;
      stable_r  <= 4'h0;
      deb_cnt_r <= '0;
    end else begin
      sync1_r <= {bus.key_vld_i, bus.key_i3};
      sync2_r <= sync1_r;
      if (samp != cand_r) begin
        cand_r    <= samp;
        deb_cnt_r <= '0;
      end else if (!deb_done) begin
        deb_cnt_r <= deb_cnt_r + DW'(1);
      end
      if (fire) stable_r <= cand_r;
    end
  end

  logic [3:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PW-1:0] cnt_w, left_w, rd_nxt;
  logic          empty_w, full_w;
  logic          do_pop, do_push, ovf_set;
  logic [3:0]    dout_r, head_nxt;
  logic          ovf_r;

  assign cnt_w   = wr_ptr_r - rd_ptr_r;
  assign empty_w = cnt_w == '0;
  assign full_w  = cnt_w == PW'(DEPTH);
  assign do_pop  = bus.rd_i && !empty_w;
  assign do_push = ev_push && (!full_w || do_pop);
  assign ovf_set = ev_push && full_w && !do_pop;
  assign rd_nxt  = rd_ptr_r + PW'(do_pop);
  assign left_w  = cnt_w - PW'(do_pop);

  // Show-ahead head: a push into an emptying queue bypasses the array
  always_comb begin
    head_nxt = 4'h0;
    if (left_w != '0)
      head_nxt = mem_r[rd_nxt[ADDR_W-1:0]];
    else if (do_push)
      head_nxt = ev_data;
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !bus.clr_i)
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= ev_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      dout_r   <= 4'h0;
      ovf_r    <= 1'b0;
    end else if (bus.clr_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      dout_r   <= 4'h0;
      ovf_r    <= 1'b0;
    end else begin
      rd_ptr_r <= rd_nxt;
      if (do_push) wr_ptr_r <= wr_ptr_r + PW'(1);
      dout_r <= head_nxt;
      if (ovf_set) ovf_r <= 1'b1;
    end
  end

  logic [BW-1:0] beep_cnt_r;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      beep_cnt_r <= '0;
    else if (beep_hit)
      beep_cnt_r <= BW'(BEEP_CYC);
    else if (beep_cnt_r != '0)
      beep_cnt_r <= beep_cnt_r - BW'(1);
  end

  assign bus.dout_o4 = dout_r;
  assign bus.cnt_o   = cnt_w;
  assign bus.empty_o = empty_w;
  assign bus.full_o  = full_w;
  assign bus.irq_o   = !empty_w;
  assign bus.ovf_o   = ovf_r;
  assign bus.beep_o  = beep_cnt_r != '0;
endmodule

// File: tb/tb_key_evt_fifo.sv
// Bench for key_evt_fifo: directed scenarios plus random
// key/pop/flush/reset traffic against a window-based model.
module tb_key_evt_fifo;
  localparam int AW    = 2;
  localparam int DEB   = 4;
  localparam int BEEP  = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  dout;
    logic [AW:0] cnt;
    logic        empty;
    logic        full;
    logic        irq;
    logic        ovf;
    logic        beep;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  key_evt_if #(.ADDR_W(AW)) bus ();

  key_evt_fifo #(
    .ADDR_W(AW), .DEB_CYC(DEB), .BEEP_CYC(BEEP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: an event is due when the last DEB
  // sampled inputs, seen through the 2-flop delay, agree.
  logic [3:0] hist [$];
  logic [3:0] m_q  [$];
  logic [3:0] m_stable;
  logic       m_ovf;
  int         ecnt, lp;
  bit         have_lp;
  obs_t       exp_q [$];

  function automatic obs_t cur_exp();
    obs_t e;
    e.dout  = (m_q.size() > 0) ? m_q[0] : 4'h0;
    e.cnt   = (AW+1)'(m_q.size());
    e.empty = m_q.size() == 0;
    e.full  = m_q.size() == DEPTH;
    e.irq   = m_q.size() != 0;
    e.ovf   = m_ovf;
    e.beep  = have_lp && ((ecnt - lp) < BEEP);
    return e;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(4'h0);
    m_q.delete();
    m_stable = 4'h0;
    m_ovf    = 1'b0;
    ecnt     = 0;
    lp       = 0;
    have_lp  = 0;
  endfunction

  function automatic void model_step();
    logic [3:0] v, inp;
    bit steady, has_ev, pop, ev_ok, beep_ev;
    logic [3:0] ent;
    ecnt++;
    v = hist[0];
    steady = 1;
    for (int i = 1; i < DEB; i++)
      if (hist[i] != v) steady = 0;
    inp = bus.key_vld_i ? {1'b1, bus.key_i3} : 4'h0;
    hist.push_back(inp);
    void'(hist.pop_front());
    has_ev = steady && (v != m_stable);
    ev_ok = 0;
    beep_ev = 0;
    ent = 4'h0;
    if (has_ev) begin
      if (v[3]) begin
        ent = {1'b0, v[2:0]};
        ev_ok = v[2:0] < 6;
        beep_ev = ev_ok;
      end else begin
        ent = {1'b1, m_stable[2:0]};
        ev_ok = m_stable[2:0] < 6;
      end
      m_stable = v;
    end
    pop = bus.rd_i && (m_q.size() > 0);
    if (bus.clr_i) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (ev_ok) begin
        if (m_q.size() < DEPTH) m_q.push_back(ent);
        else m_ovf = 1'b1;
      end
    end
    if (beep_ev) begin
      lp = ecnt;
      have_lp = 1;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(cur_exp());
    end else begin
      model_step();
      exp_q.push_back(cur_exp());
    end
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.dout_o4, bus.cnt_o, bus.empty_o, bus.full_o,
           bus.irq_o, bus.ovf_o, bus.beep_o};
      n_chk++;
      if (a !== e) begin
        n_err++;
        $display("FAIL obs @%0t: got d=%h c=%0d e%b f%b i%b o%b b%b, expected d=%h c=%0d e%b f%b i%b o%b b%b",
          $time, a.dout, a.cnt, a.empty, a.full, a.irq, a.ovf, a.beep,
          e.dout, e.cnt, e.empty, e.full, e.irq, e.ovf, e.beep);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic key(input logic v, input logic [2:0] c);
    bus.key_vld_i = v;
    bus.key_i3 = c;
  endtask

  task automatic pop(input int n);
    bus.rd_i = 1'b1;
    step(n);
    bus.rd_i = 1'b0;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Edges from the sampling edge until an entry is visible
  task automatic lat_chk(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.empty_o && n < 20);
    #1;
    chk(nm, n - 1, DEB + 2);
  endtask

  int hold;

  initial begin
    rst = 1'b1;
    key(1'b0, 3'd0);
    bus.rd_i = 1'b0;
    bus.clr_i = 1'b0;
    step(3);
    chk("rst_empty", int'(bus.empty_o), 1);
    chk("rst_cnt", int'(bus.cnt_o), 0);
    rst = 1'b0;
    step(2);

    key(1'b1, 3'd3);
    lat_chk("press_latency");
    step(13);
    key(1'b0, 3'd3);
    step(20);
    chk("s1_cnt", int'(bus.cnt_o), 2);
    chk("s1_head0", int'(bus.dout_o4), 4'h3);
    pop(1);
    chk("s1_head1", int'(bus.dout_o4), 4'hB);
    pop(1);
    chk("s1_empty", int'(bus.empty_o), 1);

    for (int i = 0; i < 3; i++) begin
      key(1'b1, 3'd5);
      step(3);
      key(1'b0, 3'd5);
      step(3);
    end
    key(1'b1, 3'd5);
    step(15);
    chk("bounce_cnt", int'(bus.cnt_o), 1);
    chk("bounce_head", int'(bus.dout_o4), 4'h5);
    key(1'b0, 3'd5);
    step(10);
    pop(2);

    for (int i = 0; i < 5; i++) begin
      key(1'b1, 3'(i));
      step(8);
      key(1'b0, 3'(i));
      step(8);
    end
    chk("ovf_full", int'(bus.full_o), 1);
    chk("ovf_flag", int'(bus.ovf_o), 1);
    chk("ovf_cnt", int'(bus.cnt_o), 4);
    begin
      logic [3:0] seq [4] = '{4'h0, 4'h8, 4'h1, 4'h9};
      for (int i = 0; i < 4; i++) begin
        chk("ovf_order", int'(bus.dout_o4), int'(seq[i]));
        pop(1);
      end
    end
    chk("drain_empty", int'(bus.empty_o), 1);
    chk("drain_irq", int'(bus.irq_o), 0);
    bus.clr_i = 1'b1;
    step(1);
    bus.clr_i = 1'b0;
    chk("clr_ovf", int'(bus.ovf_o), 0);

    for (int i = 1; i <= 2; i++) begin
      key(1'b1, 3'(i));
      step(8);
      key(1'b0, 3'(i));
      step(8);
    end
    key(1'b1, 3'd3);
    step(6);
    bus.rd_i = 1'b1;
    step(1);
    bus.rd_i = 1'b0;
    chk("fullrw_cnt", int'(bus.cnt_o), 4);
    chk("fullrw_ovf", int'(bus.ovf_o), 0);
    begin
      logic [3:0] seq [4] = '{4'h9, 4'h2, 4'hA, 4'h3};
      for (int i = 0; i < 4; i++) begin
        chk("fullrw_order", int'(bus.dout_o4), int'(seq[i]));
        pop(1);
      end
    end
    key(1'b0, 3'd3);
    step(20);
    pop(1);

    key(1'b1, 3'd7);
    step(10);
    chk("bad_beep", int'(bus.beep_o), 0);
    chk("bad_empty", int'(bus.empty_o), 1);
    key(1'b0, 3'd7);
    step(10);
    chk("bad_rel", int'(bus.empty_o), 1);

    key(1'b1, 3'd1);
    step(8);
    key(1'b1, 3'd2);
    step(8);
    chk("pre_rst_cnt", int'(bus.cnt_o), 2);
    chk("pre_rst_beep", int'(bus.beep_o), 1);
    rst = 1'b1;
    #1;
    chk("rst_cnt2", int'(bus.cnt_o), 0);
    chk("rst_beep2", int'(bus.beep_o), 0);
    chk("rst_irq2", int'(bus.irq_o), 0);
    #1;
    step(2);
    rst = 1'b0;
    lat_chk("repress_latency");
    chk("repress_head", int'(bus.dout_o4), 4'h2);

    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        key(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      bus.rd_i  = $urandom_range(0, 3) == 0;
      bus.clr_i = $urandom_range(0, 63) == 0;
      rst       = $urandom_range(0, 499) == 0;
      step(1);
    end
    rst = 1'b0;
    bus.rd_i = 1'b0;
    bus.clr_i = 1'b0;
    step(2);

    if (n_chk < 1000) begin
      n_err++;
      $display("FAIL too_few_checks: got %0d expected >= 1000", n_chk);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/key_evt_fifo.md
# key_evt_fifo

Downstream consumer of the keypad scanner (key_ctrl). It synchronises the scanner's key code and pressed flag into the 50 MHz system clock domain and debounces them. Each press and release becomes an event, queued in a small FIFO that the 8051-side CPLD bus logic drains. Each accepted press also gates a key-click enable for the buzzer driver.

## Interface
- ADDR_W, 2, FIFO address width; depth = 2**ADDR_W entries
- DEB_CYC, 1000000, consecutive stable cycles required to accept a new key state (20 ms at 50 MHz); must be ≥2
- BEEP_CYC, 2500000, beep_o high time in cycles per accepted press (50 ms)
- clk_i  in  1  system clock, 50 MHz; one clock domain
- rst_i  in  1  reset, asynchronous, active-high
- key_i3  in  3  key code from scanner (valid codes 0..5); asynchronous to clk_i
- key_vld_i  in  1  scanner pressed flag (1 = key held); asynchronous to clk_i
- rd_i  in  1  pop strobe, one cycle per entry
- clr_i  in  1  synchronous flush of FIFO and overflow flag
- dout_o4  out  4  head entry {rel, code[2:0]}; 4'h0 when empty
- cnt_o  out  ADDR_W+1  number of queued entries
- empty_o  out  1  FIFO empty
- full_o  out  1  FIFO full
- irq_o  out  1  interrupt request to MCU, equal to !empty_o
- ovf_o  out  1  sticky: an event was dropped because FIFO was full
- beep_o  out  1  key-click enable for buzzer driver

## Operation
- Reset values: all sync/debounce registers 0, pointers 0, dout_o4=0, cnt_o=0, empty_o=1, full_o=0, irq_o=0, ovf_o=0, beep_o=0. Stable state resets to {vld=0, code=0}.
- Synchroniser: two flops on {key_vld_i, key_i3} as a 4-bit vector.
- Debounce: candidate register cand_r and counter deb_cnt.
  - When sync output ≠ cand_r: load cand_r, clear deb_cnt.
  - When sync output = cand_r: deb_cnt saturates at DEB_CYC-1.
  - When deb_cnt = DEB_CYC-1 and cand_r ≠ stable_r: stable_r ← cand_r and one event fires in that cycle.
  - Code bits are ignored when vld=0: the candidate compares as {0,000}.
- Event decode from old stable → new stable:
  - vld 0→1: press, entry {0,code}.
  - vld 1→0: release, entry {1,old code}.
  - vld 1→1 with a new code: press of the new code only; no release entry.
  - A press with code 6 or 7 is invalid. stable_r still updates, but nothing is pushed and beep_o is not triggered. A later release from an invalid code is also not pushed.
- FIFO: show-ahead register array with read/write pointers of ADDR_W+1 bits (wrap bit distinguishes full from empty).
  - Push when an event fires and the FIFO is not full. If full, the event is dropped and ovf_o is set.
  - Pop on rd_i when not empty. rd_i while empty is ignored.
  - Push and pop in the same cycle:
    - not full, not empty: both occur; count unchanged.
    - full: both occur; no overflow.
    - empty: push only.
- clr_i: pointers and count go to 0 and ovf_o clears. It has priority over a same-cycle push or pop; that event is lost and ovf_o is not set. Debounce state and beep are unaffected.
- Beep: each valid press event loads the beep counter with BEEP_CYC, including presses dropped for full. beep_o = (counter ≠ 0). A retrigger while running reloads the counter.
- Outputs empty_o, full_o, cnt_o, irq_o, ovf_o and dout_o4 are driven from registers only, with no combinational path from inputs.

## Timing
- Input change to event: a change sampled by the first sync flop at edge k reaches cand_r at k+2. The event fires in the cycle of edge k+2+DEB_CYC-1. The entry is visible (empty_o=0, irq_o=1, dout_o4 valid) after edge k+2+DEB_CYC.
- A change that does not persist for DEB_CYC consecutive cycles at the sync output produces no event.
- Pop: rd_i high at edge n updates dout_o4, cnt_o and flags after edge n. The next entry is presented with zero added latency.
- beep_o rises on the same edge the press entry is written, and falls exactly BEEP_CYC cycles later if not retriggered.
- Asynchronous reset mid-operation clears everything immediately, including a running beep and a partial debounce. After release, a key still held is re-detected as a fresh press after DEB_CYC+2 cycles.

## Test plan
All scenarios use DEB_CYC=4, BEEP_CYC=8, ADDR_W=2.
- Press code 3 (vld=1) held 20 cycles, then release held 20 cycles -> entries 4'h3 then 4'hB. beep_o high for exactly 8 cycles starting with the first entry. Entry visible 6 edges after the input change.
- A bounce of 3-cycle pulses on vld, then a stable press of code 5 -> exactly one entry 4'h5, no spurious release entries.
- Five press/release pairs with no reads -> 4 entries queued, full_o=1, ovf_o=1. Pop 4 times -> dout_o4 sequence matches event order, empty_o=1, irq_o=0. clr_i -> ovf_o=0.
- With the FIFO full, a push coincides with rd_i -> cnt_o stays 4, ovf_o stays 0, the new entry is last in order.
- Press of code 7 -> no entry, beep_o stays 0. A subsequent release -> no entry.
- rst_i asserted during a beep with 2 entries queued -> all outputs at reset values on the same cycle. With vld held through reset, a new press entry appears after reset deasserts.
